// File: rtl/io_bank_if.sv
// Signal bundle for io_bank: serial configuration chain, pad-cell split I/O and fabric data.
interface io_bank_if #(parameter int NUM_PADS = 4);
   logic                prog_in;
   logic                prog_en;
   logic                prog_out;
   logic [NUM_PADS-1:0] pad_in;
   logic [NUM_PADS-1:0] pad_out;
   logic [NUM_PADS-1:0] pad_oe;
   logic [NUM_PADS-1:0] pad_pu;
   logic [NUM_PADS-1:0] pad_pd;
   logic [NUM_PADS-1:0] fab_out;
   logic [NUM_PADS-1:0] fab_in;
   logic                cfg_done;
   logic                cfg_valid;
   logic [NUM_PADS-1:0] cfg_conflict;

   modport master (
      output prog_in, prog_en, pad_in, fab_out,
      input  prog_out, pad_out, pad_oe, pad_pu, pad_pd, fab_in,
             cfg_done, cfg_valid, cfg_conflict
   );

   modport slave (
      input  prog_in, prog_en, pad_in, fab_out,
      output prog_out, pad_out, pad_oe, pad_pu, pad_pd, fab_in,
             cfg_done, cfg_valid, cfg_conflict
   );
endinterface

// File: rtl/io_bank.sv
// Multi-pad configurable I/O bank with a serial shadow chain and atomic commit.
// Optional macro IO_BANK_SYNC_EN adds a two-flop synchroniser on pad_in.
module io_bank #(
   parameter int NUM_PADS = 4,
   parameter int CFG_BITS = 4
) (
   input logic     prog_clk,
   input logic     prog_rst,
   io_bank_if.slave bus
);
   localparam int CHAIN_LEN = NUM_PADS * CFG_BITS;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t              state;
   logic [CHAIN_LEN-1:0] shadow;
   logic [CHAIN_LEN-1:0] control;
   logic                cfg_done_q;
   logic                cfg_valid_q;
   logic [NUM_PADS-1:0] pad_in_s;
   logic [NUM_PADS-1:0] in_q;
   logic [NUM_PADS-1:0] out_q;
   logic [NUM_PADS-1:0] oe_c, out_c, in_c, pu_c, pd_c, conflict_c;

   // Shadow shifts whenever prog_en is high; control only moves on the SHIFT->COMMIT edge.
   always_ff @(posedge prog_clk or posedge prog_rst) begin
      if (prog_rst) begin
         state       <= IDLE;
         shadow      <= '0;
         control     <= '0;
         cfg_done_q  <= 1'b0;
         cfg_valid_q <= 1'b0;
      end else begin
         cfg_done_q <= 1'b0;
         if (bus.prog_en)
            shadow <= {shadow[CHAIN_LEN-2:0], bus.prog_in};
         case (state)
            IDLE:    if (bus.prog_en) state <= SHIFT;
            SHIFT: begin
               if (!bus.prog_en) begin
                  control     <= shadow;
                  state       <= COMMIT;
                  cfg_done_q  <= 1'b1;
                  cfg_valid_q <= 1'b1;
               end
            end
            COMMIT:  state <= bus.prog_en ? SHIFT : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IO_BANK_SYNC_EN
   logic [NUM_PADS-1:0] sync1;
   logic [NUM_PADS-1:0] sync2;

   always_ff @(posedge prog_clk or posedge prog_rst) begin
      if (prog_rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.pad_in;
         sync2 <= sync1;
      end
   end

   assign pad_in_s = sync2;
`else
   assign pad_in_s = bus.pad_in;
`endif

   always_ff @(posedge prog_clk or posedge prog_rst) begin
      if (prog_rst) begin
         in_q  <= '0;
         out_q <= '0;
      end else begin
         in_q  <= pad_in_s;
         out_q <= bus.fab_out;
      end
   end

   // Field layout per pad: bit0 DIR, bit1 PULL_DOWN, bit2 PULL_UP, bit3 REG.
   always_comb begin
      oe_c       = '0;
      out_c      = '0;
      in_c       = '0;
      pu_c       = '0;
      pd_c       = '0;
      conflict_c = '0;
      for (int k = 0; k < NUM_PADS; k++) begin
         oe_c[k]       = cfg_valid_q & ~control[k*CFG_BITS];
         out_c[k]      = control[k*CFG_BITS] ? 1'b0
                       : (control[k*CFG_BITS+3] ? out_q[k] : bus.fab_out[k]);
         in_c[k]       = control[k*CFG_BITS]
                       ? (control[k*CFG_BITS+3] ? in_q[k] : pad_in_s[k]) : 1'b0;
         pu_c[k]       = control[k*CFG_BITS+2] & ~control[k*CFG_BITS+1];
         pd_c[k]       = control[k*CFG_BITS+1] & ~control[k*CFG_BITS+2];
         conflict_c[k] = control[k*CFG_BITS+1] & control[k*CFG_BITS+2];
      end
   end

   assign bus.prog_out     = shadow[CHAIN_LEN-1];
   assign bus.pad_oe       = oe_c;
   assign bus.pad_out      = out_c;
   assign bus.fab_in       = in_c;
   assign bus.pad_pu       = pu_c;
   assign bus.pad_pd       = pd_c;
   assign bus.cfg_conflict = conflict_c;
   assign bus.cfg_done     = cfg_done_q;
   assign bus.cfg_valid    = cfg_valid_q;
endmodule

// File: tb/tb_io_bank.sv
// Randomized self-checking bench for io_bank against a bit-history reference model.
module tb_io_bank;
   localparam int NP = 4;
   localparam int CL = NP * 4;
`ifdef IO_BANK_SYNC_EN
   localparam int SYNC_D = 2;
`else
   localparam int SYNC_D = 0;
`endif

   logic prog_clk;
   logic prog_rst;

   io_bank_if #(.NUM_PADS(NP)) bus ();

   io_bank #(.NUM_PADS(NP), .CFG_BITS(4)) dut (
      .prog_clk (prog_clk),
      .prog_rst (prog_rst),
      .bus      (bus)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   int assertCount = 0;
   int failCount   = 0;

   logic        hist[$];
   logic [3:0]  padHist[$];
   logic [3:0]  fabHist[$];
   logic [CL-1:0] ctrlM;
   logic        validM;
   logic        doneM;
   logic        prevEn;
   logic [3:0]  padInV;
   logic [3:0]  fabOutV;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // The chain is a history of every bit shifted in; the last CL bits are the shadow.
   task automatic modelReset();
      hist.delete();
      for (int i = 0; i < CL; i++) hist.push_back(1'b0);
      padHist.delete();
      fabHist.delete();
      for (int i = 0; i < 4; i++) begin
         padHist.push_back(4'h0);
         fabHist.push_back(4'h0);
      end
      ctrlM  = '0;
      validM = 1'b0;
      doneM  = 1'b0;
      prevEn = 1'b0;
   endtask

   task automatic step();
      @(posedge prog_clk);
      padHist.push_front(padInV);
      void'(padHist.pop_back());
      fabHist.push_front(fabOutV);
      void'(fabHist.pop_back());
      doneM = 1'b0;
      if (bus.prog_en) begin
         hist.push_back(bus.prog_in);
         if (hist.size() > 4 * CL) void'(hist.pop_front());
      end else if (prevEn) begin
         for (int p = 0; p < CL; p++) ctrlM[p] = hist[hist.size() - 1 - p];
         doneM  = 1'b1;
         validM = 1'b1;
      end
      prevEn = bus.prog_en;
      #1;
   endtask

   task automatic checkAll();
      logic [3:0] eOe, eOut, eIn, ePu, ePd, eCf;
      logic [3:0] f;
      int d;
      for (int k = 0; k < NP; k++) begin
         f      = ctrlM[k*4 +: 4];
         eOe[k] = validM & ~f[0];
         eOut[k] = f[0] ? 1'b0 : (f[3] ? fabHist[0][k] : fabOutV[k]);
         d      = SYNC_D + (f[3] ? 1 : 0);
         if (!f[0])      eIn[k] = 1'b0;
         else if (d == 0) eIn[k] = padInV[k];
         else            eIn[k] = padHist[d-1][k];
         ePu[k] = f[2] & ~f[1];
         ePd[k] = f[1] & ~f[2];
         eCf[k] = f[1] & f[2];
      end
      checkOutput("pad_oe",       32'(bus.pad_oe),       32'(eOe));
      checkOutput("pad_out",      32'(bus.pad_out),      32'(eOut));
      checkOutput("fab_in",       32'(bus.fab_in),       32'(eIn));
      checkOutput("pad_pu",       32'(bus.pad_pu),       32'(ePu));
      checkOutput("pad_pd",       32'(bus.pad_pd),       32'(ePd));
      checkOutput("cfg_conflict", 32'(bus.cfg_conflict), 32'(eCf));
      checkOutput("cfg_done",     32'(bus.cfg_done),     32'(doneM));
      checkOutput("cfg_valid",    32'(bus.cfg_valid),    32'(validM));
      checkOutput("prog_out",     32'(bus.prog_out),     32'(hist[hist.size() - CL]));
   endtask

   task automatic applyStimulus(input logic en, input logic bitIn, input logic rnd);
      if (rnd) begin
         padInV  = 4'($urandom);
         fabOutV = 4'($urandom);
      end
      bus.prog_en = en;
      bus.prog_in = bitIn;
      bus.pad_in  = padInV;
      bus.fab_out = fabOutV;
      #2;
      checkAll();
      step();
   endtask

   task automatic loadConfig(input logic [CL-1:0] cfg);
      for (int i = 0; i < CL; i++) applyStimulus(1'b1, cfg[CL-1-i], 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("done_pulse", 32'(bus.cfg_done), 32'd1);
      checkOutput("valid_set",  32'(bus.cfg_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("done_single", 32'(bus.cfg_done), 32'd0);
   endtask

   logic bits[32];

   initial begin
      prog_rst    = 1'b1;
      padInV      = 4'hF;
      fabOutV     = 4'hF;
      bus.prog_en = 1'b0;
      bus.prog_in = 1'b0;
      bus.pad_in  = padInV;
      bus.fab_out = fabOutV;
      modelReset();
      #3;
      checkOutput("rst_pad_oe",    32'(bus.pad_oe),    32'd0);
      checkOutput("rst_fab_in",    32'(bus.fab_in),    32'd0);
      checkOutput("rst_pad_pu",    32'(bus.pad_pu),    32'd0);
      checkOutput("rst_pad_pd",    32'(bus.pad_pd),    32'd0);
      checkOutput("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
      checkOutput("rst_prog_out",  32'(bus.prog_out),  32'd0);
      #20;
      prog_rst = 1'b0;
      step();

      // All inputs, unregistered
      loadConfig(16'h1111);
      padInV = 4'hA;
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("in_fab_in", 32'(bus.fab_in), 32'hA);
      checkOutput("in_pad_oe", 32'(bus.pad_oe), 32'h0);

      // All outputs, registered
      loadConfig(16'h8888);
      fabOutV = 4'h0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      fabOutV = 4'hF;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("reg_pad_out", 32'(bus.pad_out), 32'hF);
      checkOutput("reg_pad_oe",  32'(bus.pad_oe),  32'hF);
      checkOutput("reg_fab_in",  32'(bus.fab_in),  32'h0);

      // Pad0 with both pulls set
      loadConfig(16'h5A36);
      checkOutput("cf_conflict", 32'(bus.cfg_conflict), 32'b0001);
      checkOutput("cf_pad_pu",   32'(bus.pad_pu),       32'b1000);
      checkOutput("cf_pad_pd",   32'(bus.pad_pd),       32'b0110);

      // Chain pass-through with prog_en held high
      for (int j = 0; j < 32; j++) bits[j] = 1'($urandom);
      for (int j = 0; j < 32; j++) begin
         if (j >= CL) checkOutput("chain", 32'(bus.prog_out), 32'(bits[j-CL]));
         applyStimulus(1'b1, bits[j], 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);

      repeat (6) loadConfig(16'($urandom));

      // Reset in the middle of a load
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'($urandom), 1'b1);
      prog_rst = 1'b1;
      #2;
      modelReset();
      checkAll();
      @(posedge prog_clk);
      #3;
      bus.prog_en = 1'b0;
      prog_rst    = 1'b0;
      step();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("abort_done",  32'(bus.cfg_done),  32'd0);
      checkOutput("abort_valid", 32'(bus.cfg_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);

      // Single-cycle prog_en still shifts one bit and commits
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("one_bit_done", 32'(bus.cfg_done), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
